// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with load-use stall, branch flush and event counters
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              id_ALUSrc,
    input  logic              id_MemtoReg,
    input  logic              id_RegWrite,
    input  logic              id_MemRead,
    input  logic              id_MemWrite,
    input  logic              id_Branch,
    input  logic [1:0]        id_ALUOp,
    input  logic [PC_W-1:0]   id_pc,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [2:0]        id_funct3,
    input  logic [6:0]        id_funct7,
    input  logic              flush,
    output logic              ex_valid,
    output logic              ex_ALUSrc,
    output logic              ex_MemtoReg,
    output logic              ex_RegWrite,
    output logic              ex_MemRead,
    output logic              ex_MemWrite,
    output logic              ex_Branch,
    output logic [1:0]        ex_ALUOp,
    output logic [PC_W-1:0]   ex_pc,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [2:0]        ex_funct3,
    output logic [6:0]        ex_funct7,
    output logic              stall_if_id,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    // Control bundle packed as {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0]}
    logic              valid_q, valid_d;
    logic [7:0]        ctrl_q, ctrl_d;
    logic [PC_W-1:0]   pc_q;
    logic [DATA_W-1:0] rd1_q, rd2_q, imm_q;
    logic [4:0]        rs1_q, rs2_q, rd_q;
    logic [2:0]        funct3_q;
    logic [6:0]        funct7_q;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic [7:0] id_ctrl;
    logic       uses_rs2;
    logic       hazard;

    assign id_ctrl  = {id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead,
                       id_MemWrite, id_Branch, id_ALUOp};

    // Stores read rs2 as data even though ALUSrc selects the immediate
    assign uses_rs2 = ~id_ALUSrc | id_MemWrite;

    // Load in EX whose destination feeds the instruction now in ID; x0 never hazards
    assign hazard = valid_q & ctrl_q[4] & (rd_q != 5'd0) & id_valid &
                    ((rd_q == id_rs1) | (uses_rs2 & (rd_q == id_rs2)));

    // A flushed ID instruction is discarded anyway, so there is nothing to stall for
    assign stall_if_id = hazard & ~flush;

    // Next-state selection: flush beats hazard beats normal advance; counters saturate
    always_comb begin
        valid_d     = id_valid;
        ctrl_d      = id_valid ? id_ctrl : 8'h00;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = 8'h00;
            if (id_valid && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end else if (hazard) begin
            valid_d = 1'b0;
            ctrl_d  = 8'h00;
            if (stall_cnt_q != {CNT_W{1'b1}}) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
    end

    // Pipeline register: data fields always load, valid/ctrl take the squashed next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            ctrl_q      <= 8'h00;
            pc_q        <= '0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            imm_q       <= '0;
            rs1_q       <= 5'd0;
            rs2_q       <= 5'd0;
            rd_q        <= 5'd0;
            funct3_q    <= 3'd0;
            funct7_q    <= 7'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            ctrl_q      <= ctrl_d;
            pc_q        <= id_pc;
            rd1_q       <= id_rd1;
            rd2_q       <= id_rd2;
            imm_q       <= id_imm;
            rs1_q       <= id_rs1;
            rs2_q       <= id_rs2;
            rd_q        <= id_rd;
            funct3_q    <= id_funct3;
            funct7_q    <= id_funct7;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_ALUSrc   = ctrl_q[7];
    assign ex_MemtoReg = ctrl_q[6];
    assign ex_RegWrite = ctrl_q[5];
    assign ex_MemRead  = ctrl_q[4];
    assign ex_MemWrite = ctrl_q[3];
    assign ex_Branch   = ctrl_q[2];
    assign ex_ALUOp    = ctrl_q[1:0];
    assign ex_pc       = pc_q;
    assign ex_rd1      = rd1_q;
    assign ex_rd2      = rd2_q;
    assign ex_imm      = imm_q;
    assign ex_rs1      = rs1_q;
    assign ex_rs2      = rs2_q;
    assign ex_rd       = rd_q;
    assign ex_funct3   = funct3_q;
    assign ex_funct7   = funct7_q;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule
